// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at a time; request accepted on imem_req && imem_ready.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, single-outstanding imem fetch FSM, IF/ID register; FETCH_PERF_CNT_EN adds perf counters.
// Latency: request in IDLE, IF/ID written on the response cycle (one instruction per 2 cycles at zero wait).
// Backpressure: hazard stall parks a returned instruction in a one-entry buffer (HOLD) until delivery.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_write_enable,
    input  logic          if_id_write_enable,
    input  logic          pc_redirect,
    input  logic [31:0]   redirect_target,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_instr,
    output logic          if_id_valid,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   redirect_count
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_buf;
    logic [31:0] w_buf_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] r_if_instr;
    logic [31:0] w_if_instr_nxt;
    logic        r_if_valid;
    logic        w_if_valid_nxt;

    logic        w_deliver;
    logic        w_redirect;
    logic        w_accept;
    logic [31:0] w_pc_inc;
    logic [31:0] w_target;

    assign w_deliver  = pc_write_enable & if_id_write_enable;
    assign w_redirect = pc_redirect & pc_write_enable;
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_target   = {redirect_target[31:2], 2'b00};

    // Gated by rst_n so no request is presented while reset is asserted.
    assign imem.imem_req  = rst_n & (r_state == IDLE);
    assign imem.imem_addr = r_pc;
    assign w_accept       = imem.imem_req & imem.imem_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_buf_nxt      = r_buf;
        w_if_pc_nxt    = r_if_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_valid_nxt = r_if_valid;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    if (w_deliver) begin
                        w_if_pc_nxt    = r_pc;
                        w_if_instr_nxt = imem.imem_rdata;
                        w_if_valid_nxt = 1'b1;
                        w_pc_nxt       = w_pc_inc;
                        w_state_nxt    = IDLE;
                    end else begin
                        w_buf_nxt   = imem.imem_rdata;
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (w_deliver) begin
                    w_if_pc_nxt    = r_pc;
                    w_if_instr_nxt = r_buf;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = w_pc_inc;
                    w_state_nxt    = IDLE;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Redirect overrides the normal path: flush IF/ID but keep its PC.
        if (w_redirect) begin
            w_pc_nxt       = w_target;
            w_if_pc_nxt    = r_if_pc;
            w_if_instr_nxt = NOP_INSTR;
            w_if_valid_nxt = 1'b0;
            case (r_state)
                IDLE:    w_state_nxt = w_accept ? DROP : IDLE;
                WAIT:    w_state_nxt = imem.imem_rvalid ? IDLE : DROP;
                HOLD:    w_state_nxt = IDLE;
                // The stale response landing this same cycle is the one DROP waits for.
                default: w_state_nxt = imem.imem_rvalid ? IDLE : DROP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_buf      <= '0;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_buf      <= w_buf_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

    assign if_id_pc    = r_if_pc;
    assign if_id_instr = r_if_instr;
    assign if_id_valid = r_if_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_redirect_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles   <= '0;
            r_redirect_count <= '0;
        end else begin
            if (!if_id_write_enable && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (w_redirect && (r_redirect_count != 32'hFFFF_FFFF)) begin
                r_redirect_count <= r_redirect_count + 32'd1;
            end
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign redirect_count = r_redirect_count;
`else
    assign stall_cycles   = '0;
    assign redirect_count = '0;
`endif

endmodule
